// File: rtl/branch_unit_pkg.sv
// Shared encodings for the branch unit: opcodes, ALU function codes, branch
// conditions, flag bit positions and the control state enum.
package branch_unit_pkg;

    localparam logic [1:0] OP_ALU = 2'b11;

    localparam logic [3:0] F_ADD = 4'b0000;
    localparam logic [3:0] F_ADC = 4'b0001;
    localparam logic [3:0] F_SUB = 4'b0010;
    localparam logic [3:0] F_SBC = 4'b0011;
    localparam logic [3:0] F_AND = 4'b0100;
    localparam logic [3:0] F_CMP = 4'b0101;
    localparam logic [3:0] F_SLL = 4'b1000;
    localparam logic [3:0] F_SLR = 4'b1001;
    localparam logic [3:0] F_SRL = 4'b1010;
    localparam logic [3:0] F_SRA = 4'b1011;
    localparam logic [3:0] F_OUT = 4'b1101;
    localparam logic [3:0] F_HLT = 4'b1111;

    localparam logic [4:0] BR_B    = 5'b10100;
    localparam logic [4:0] BR_COND = 5'b10111;

    localparam logic [2:0] CC_BE  = 3'b000;
    localparam logic [2:0] CC_BLT = 3'b001;
    localparam logic [2:0] CC_BLE = 3'b010;
    localparam logic [2:0] CC_BNE = 3'b011;

    localparam int FLAG_S = 3;
    localparam int FLAG_Z = 2;
    localparam int FLAG_C = 1;
    localparam int FLAG_V = 0;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_FLUSH = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // Arithmetic, logic and shift functions update flags; moves and I/O do not.
    function automatic logic is_flag_setter(input logic [15:0] instr);
        logic [3:0] op3;
        op3 = instr[7:4];
        return (instr[15:14] == OP_ALU) &&
               ((op3 <= F_CMP) || ((op3 >= F_SLL) && (op3 <= F_SRA)));
    endfunction

endpackage

// File: rtl/branch_unit_cond.sv
// Combinational branch condition evaluation against the latched {S,Z,C,V}.
module branch_cond
    import branch_unit_pkg::*;
(
    input  logic [3:0] flags,
    input  logic [2:0] cond,
    output logic       taken
);

    logic s_xor_v;

    assign s_xor_v = flags[FLAG_S] ^ flags[FLAG_V];

    always_comb begin
        taken = 1'b0;
        unique case (cond)
            CC_BE:   taken = flags[FLAG_Z];
            CC_BLT:  taken = s_xor_v;
            CC_BLE:  taken = flags[FLAG_Z] | s_xor_v;
            CC_BNE:  taken = ~flags[FLAG_Z];
            default: taken = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_unit.sv
// Branch resolution, flag latch and program counter for the execute stage.
// Optional branch statistics counter enabled by defining BRANCH_STATS_EN.
module branch_unit
    import branch_unit_pkg::*;
#(
    parameter logic [15:0] RESET_PC     = 16'h0000,
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [3:0]  code,
    input  logic        restart,
    output logic [15:0] pc,
    output logic        redirect,
    output logic [3:0]  flags,
    output logic        halted
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0] taken_count
`endif
);

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] pc_q, pc_d;
    logic [3:0]  flags_q, flags_d;
    logic        redirect_q, redirect_d;
    logic        halted_q, halted_d;

    logic        accept;
    logic        is_b, is_bcond, is_hlt, sets_flags;
    logic        cond_taken, taken;
    logic [15:0] disp;

    assign instr_ready = (state_q != ST_HALT);
    assign accept      = instr_valid & instr_ready;

    assign is_b       = (instr[15:11] == BR_B);
    assign is_bcond   = (instr[15:11] == BR_COND);
    assign is_hlt     = (instr[15:14] == OP_ALU) && (instr[7:4] == F_HLT);
    assign sets_flags = is_flag_setter(instr);
    assign disp       = {{8{instr[7]}}, instr[7:0]};

    // Branches see the registered flags, so a flag-setter affects the next branch.
    branch_cond u_cond (
        .flags (flags_q),
        .cond  (instr[10:8]),
        .taken (cond_taken)
    );

    assign taken = is_b | (is_bcond & cond_taken);

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        pc_d       = pc_q;
        flags_d    = flags_q;
        redirect_d = 1'b0;
        unique case (state_q)
            ST_RUN: begin
                if (accept) begin
                    pc_d = pc_q + 16'd1;
                    if (sets_flags) flags_d = code;
                    if (taken) begin
                        pc_d       = pc_q + 16'd1 + disp;
                        redirect_d = 1'b1;
                        if (FLUSH_CYCLES != 0) begin
                            state_d = ST_FLUSH;
                            cnt_d   = 4'(FLUSH_CYCLES);
                        end
                    end else if (is_hlt) begin
                        state_d = ST_HALT;
                    end
                end
            end
            ST_FLUSH: begin
                if (accept) begin
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) state_d = ST_RUN;
                end
            end
            ST_HALT: begin
                if (restart) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
        halted_d = (state_d == ST_HALT);
    end

    // NOTE: state is updated with non-blocking assignments so all flops see pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            cnt_q      <= 4'd0;
            pc_q       <= RESET_PC;
            flags_q    <= 4'd0;
            redirect_q <= 1'b0;
            halted_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            pc_q       <= pc_d;
            flags_q    <= flags_d;
            redirect_q <= redirect_d;
            halted_q   <= halted_d;
        end
    end

    assign pc       = pc_q;
    assign flags    = flags_q;
    assign redirect = redirect_q;
    assign halted   = halted_q;

`ifdef BRANCH_STATS_EN
    logic [15:0] taken_count_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            taken_count_q <= 16'd0;
        end else if (accept && (state_q == ST_RUN) && taken && (taken_count_q != 16'hFFFF)) begin
            taken_count_q <= taken_count_q + 16'd1;
        end
    end

    assign taken_count = taken_count_q;
`endif

endmodule

// File: tb/tb_branch_unit.sv
// Directed testbench for branch_unit (RESET_PC=0100, FLUSH_CYCLES=2).
// The statistics test is compiled only when BRANCH_STATS_EN is defined.
module tb_branch_unit;

    localparam logic [15:0] I_ADD = 16'hC000;
    localparam logic [15:0] I_CMP = 16'hC050;
    localparam logic [15:0] I_HLT = 16'hC0F0;
    localparam logic [15:0] I_NOP = 16'h0000;
    localparam logic [15:0] I_B   = 16'hA000;
    localparam logic [15:0] I_BE  = 16'hB800;
    localparam logic [15:0] I_BLT = 16'hB900;
    localparam logic [15:0] I_BLE = 16'hBA00;
    localparam logic [15:0] I_BNE = 16'hBB00;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  code;
    logic        restart;
    logic [15:0] pc;
    logic        redirect;
    logic [3:0]  flags;
    logic        halted;
`ifdef BRANCH_STATS_EN
    logic [15:0] taken_count;
`endif

    int checks   = 0;
    int failures = 0;
    logic [15:0] exp_pc;
    logic [3:0]  exp_flags;

    always #5 clk = ~clk;

    branch_unit #(
        .RESET_PC     (16'h0100),
        .FLUSH_CYCLES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .code        (code),
        .restart     (restart),
        .pc          (pc),
        .redirect    (redirect),
        .flags       (flags),
        .halted      (halted)
`ifdef BRANCH_STATS_EN
        ,
        .taken_count (taken_count)
`endif
    );

    // Drive one cycle of inputs at the falling edge; return 1ns after the rising edge.
    task automatic step(input logic [15:0] i, input logic [3:0] c, input logic v, input logic r);
        @(negedge clk);
        instr       = i;
        code        = c;
        instr_valid = v;
        restart     = r;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        restart     = 1'b0;
        instr       = I_NOP;
        code        = 4'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n     = 1'b1;
        exp_pc    = 16'h0100;
        exp_flags = 4'h0;
    endtask

    // Reach a target pc through unconditional branches, each followed by two flushed slots.
    task automatic goto_pc(input logic [15:0] target);
        logic [15:0] d16;
        logic [7:0]  d8;
        for (int n = 0; n < 8 && exp_pc != target; n++) begin
            d16 = target - exp_pc - 16'd1;
            if ($signed(d16) > 127)       d8 = 8'h7F;
            else if ($signed(d16) < -128) d8 = 8'h80;
            else                          d8 = d16[7:0];
            exp_pc = exp_pc + 16'd1 + {{8{d8[7]}}, d8};
            step(I_B | {8'h00, d8}, 4'h0, 1'b1, 1'b0);
            checks++;
            if (pc !== exp_pc || redirect !== 1'b1) begin
                failures++;
                $display("FAIL goto_branch pc=%h redirect=%b expected pc=%h redirect=1", pc, redirect, exp_pc);
            end
            step(I_NOP, 4'h0, 1'b1, 1'b0);
            step(I_NOP, 4'h0, 1'b1, 1'b0);
        end
        checks++;
        if (pc !== target) begin
            failures++;
            $display("FAIL goto_reached pc=%h expected %h", pc, target);
        end
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (pc !== 16'h0100 || flags !== 4'h0 || halted !== 1'b0 || redirect !== 1'b0 || instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_values pc=%h flags=%h halted=%b redirect=%b ready=%b expected 0100/0/0/0/1",
                     pc, flags, halted, redirect, instr_ready);
        end
        repeat (3) step(I_ADD, 4'h0, 1'b1, 1'b0);
        exp_pc = 16'h0103;
        checks++;
        if (pc !== 16'h0103 || flags !== 4'h0) begin
            failures++;
            $display("FAIL reset_three_adds pc=%h flags=%h expected 0103/0", pc, flags);
        end
    endtask

    task automatic test_be_flush();
        goto_pc(16'h0010);
        step(I_CMP, 4'b0100, 1'b1, 1'b0);
        exp_flags = 4'b0100;
        checks++;
        if (pc !== 16'h0011 || flags !== 4'b0100 || redirect !== 1'b0) begin
            failures++;
            $display("FAIL cmp_sets_flags pc=%h flags=%h redirect=%b expected 0011/4/0", pc, flags, redirect);
        end
        step(I_BE | 16'h00FC, 4'h0, 1'b1, 1'b0);
        checks++;
        if (pc !== 16'h000E || redirect !== 1'b1) begin
            failures++;
            $display("FAIL be_taken pc=%h redirect=%b expected 000E/1", pc, redirect);
        end
        step(I_ADD, 4'hF, 1'b1, 1'b0);
        checks++;
        if (pc !== 16'h000E || flags !== 4'b0100 || redirect !== 1'b0) begin
            failures++;
            $display("FAIL flush_discard1 pc=%h flags=%h redirect=%b expected 000E/4/0", pc, flags, redirect);
        end
        step(I_NOP, 4'h0, 1'b0, 1'b0);
        step(I_B | 16'h0040, 4'h0, 1'b1, 1'b0);
        checks++;
        if (pc !== 16'h000E || redirect !== 1'b0) begin
            failures++;
            $display("FAIL flush_discard2 pc=%h redirect=%b expected 000E/0", pc, redirect);
        end
        step(I_NOP, 4'h0, 1'b1, 1'b0);
        exp_pc = 16'h000F;
        checks++;
        if (pc !== 16'h000F) begin
            failures++;
            $display("FAIL flush_exit pc=%h expected 000F", pc);
        end
    endtask

    task automatic test_conditions();
        step(I_CMP, 4'b1000, 1'b1, 1'b0);
        step(I_BLT | 16'h0005, 4'h0, 1'b1, 1'b0);
        checks++;
        if (pc !== 16'h0016 || redirect !== 1'b1) begin
            failures++;
            $display("FAIL blt_taken pc=%h redirect=%b expected 0016/1", pc, redirect);
        end
        step(I_NOP, 4'h0, 1'b1, 1'b0);
        step(I_NOP, 4'h0, 1'b1, 1'b0);
        step(I_BLE | 16'h0002, 4'h0, 1'b1, 1'b0);
        checks++;
        if (pc !== 16'h0019 || redirect !== 1'b1) begin
            failures++;
            $display("FAIL ble_taken pc=%h redirect=%b expected 0019/1", pc, redirect);
        end
        step(I_NOP, 4'h0, 1'b1, 1'b0);
        step(I_NOP, 4'h0, 1'b1, 1'b0);
        step(I_CMP, 4'b0100, 1'b1, 1'b0);
        step(I_BNE | 16'h0010, 4'h0, 1'b1, 1'b0);
        checks++;
        if (pc !== 16'h001B || redirect !== 1'b0) begin
            failures++;
            $display("FAIL bne_not_taken pc=%h redirect=%b expected 001B/0", pc, redirect);
        end
        step(I_CMP, 4'b1001, 1'b1, 1'b0);
        step(I_BLT | 16'h0010, 4'b1000, 1'b1, 1'b0);
        exp_pc    = 16'h001D;
        exp_flags = 4'b1001;
        checks++;
        if (pc !== 16'h001D || redirect !== 1'b0 || flags !== 4'b1001) begin
            failures++;
            $display("FAIL blt_not_taken pc=%h redirect=%b flags=%h expected 001D/0/9", pc, redirect, flags);
        end
    endtask

    task automatic test_wrap();
        goto_pc(16'hFFFF);
        step(I_B | 16'h0001, 4'h0, 1'b1, 1'b0);
        checks++;
        if (pc !== 16'h0001 || redirect !== 1'b1) begin
            failures++;
            $display("FAIL wrap_up pc=%h redirect=%b expected 0001/1", pc, redirect);
        end
        step(I_NOP, 4'h0, 1'b1, 1'b0);
        step(I_NOP, 4'h0, 1'b1, 1'b0);
        exp_pc = 16'h0001;
        goto_pc(16'h0000);
        step(I_B | 16'h0080, 4'h0, 1'b1, 1'b0);
        checks++;
        if (pc !== 16'hFF81 || redirect !== 1'b1) begin
            failures++;
            $display("FAIL wrap_down pc=%h redirect=%b expected FF81/1", pc, redirect);
        end
        step(I_NOP, 4'h0, 1'b1, 1'b0);
        step(I_NOP, 4'h0, 1'b1, 1'b0);
        exp_pc = 16'hFF81;
    endtask

    task automatic test_halt();
        goto_pc(16'h0020);
        step(I_HLT, 4'h0, 1'b1, 1'b0);
        checks++;
        if (pc !== 16'h0021 || halted !== 1'b1 || instr_ready !== 1'b0) begin
            failures++;
            $display("FAIL halt_entry pc=%h halted=%b ready=%b expected 0021/1/0", pc, halted, instr_ready);
        end
        step(I_ADD, 4'hF, 1'b1, 1'b0);
        step(I_ADD, 4'hF, 1'b1, 1'b0);
        checks++;
        if (pc !== 16'h0021 || halted !== 1'b1 || instr_ready !== 1'b0 || flags !== exp_flags) begin
            failures++;
            $display("FAIL halt_hold pc=%h halted=%b ready=%b flags=%h expected 0021/1/0/%h",
                     pc, halted, instr_ready, flags, exp_flags);
        end
        step(I_NOP, 4'h0, 1'b1, 1'b1);
        checks++;
        if (pc !== 16'h0021 || halted !== 1'b0 || instr_ready !== 1'b1) begin
            failures++;
            $display("FAIL restart pc=%h halted=%b ready=%b expected 0021/0/1", pc, halted, instr_ready);
        end
        step(I_NOP, 4'h0, 1'b1, 1'b1);
        checks++;
        if (pc !== 16'h0022 || halted !== 1'b0) begin
            failures++;
            $display("FAIL restart_in_run pc=%h halted=%b expected 0022/0", pc, halted);
        end
        exp_pc = 16'h0022;
    endtask

    task automatic test_reset_mid_flush();
        step(I_B | 16'h0005, 4'h0, 1'b1, 1'b0);
        @(negedge clk);
        rst_n       = 1'b0;
        instr_valid = 1'b0;
        restart     = 1'b0;
        #1;
        checks++;
        if (pc !== 16'h0100 || redirect !== 1'b0 || flags !== 4'h0 || halted !== 1'b0) begin
            failures++;
            $display("FAIL async_reset pc=%h redirect=%b flags=%h halted=%b expected 0100/0/0/0",
                     pc, redirect, flags, halted);
        end
        @(negedge clk);
        rst_n = 1'b1;
        step(I_NOP, 4'h0, 1'b1, 1'b0);
        checks++;
        if (pc !== 16'h0101) begin
            failures++;
            $display("FAIL reset_clears_flush pc=%h expected 0101", pc);
        end
    endtask

`ifdef BRANCH_STATS_EN
    task automatic test_stats();
        do_reset();
        checks++;
        if (taken_count !== 16'h0000) begin
            failures++;
            $display("FAIL stats_reset count=%h expected 0000", taken_count);
        end
        step(I_BE, 4'h0, 1'b1, 1'b0);
        for (int k = 0; k < 3; k++) begin
            step((k == 1) ? I_B : I_BNE, 4'h0, 1'b1, 1'b0);
            step(I_BE, 4'h0, 1'b1, 1'b0);
            step(I_B, 4'h0, 1'b1, 1'b0);
        end
        step(I_BLT, 4'h0, 1'b1, 1'b0);
        checks++;
        if (taken_count !== 16'd3 || pc !== 16'h0105) begin
            failures++;
            $display("FAIL stats_count count=%h pc=%h expected 0003/0105", taken_count, pc);
        end
        force dut.taken_count_q = 16'hFFFF;
        @(negedge clk);
        release dut.taken_count_q;
        step(I_B, 4'h0, 1'b1, 1'b0);
        checks++;
        if (taken_count !== 16'hFFFF || redirect !== 1'b1) begin
            failures++;
            $display("FAIL stats_saturate count=%h redirect=%b expected FFFF/1", taken_count, redirect);
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n       = 1'b0;
        instr       = I_NOP;
        instr_valid = 1'b0;
        code        = 4'h0;
        restart     = 1'b0;
        exp_pc      = 16'h0100;
        exp_flags   = 4'h0;
        test_reset();
        test_be_flush();
        test_conditions();
        test_wrap();
        test_halt();
        test_reset_mid_flush();
`ifdef BRANCH_STATS_EN
        test_stats();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
